// File: rtl/uart_frame_loader_pkg.sv
// Shared definitions for the UART frame loader: pixel/address widths,
// the RX state encoding and a helper for the bit-period divider.
package uart_frame_loader_pkg;

  localparam int unsigned PIX_W   = 12;
  localparam int unsigned ADDR_W  = 18;
  localparam int unsigned COORD_W = 9;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_frame_loader_rx.sv
// uart_rx_byte: 8N1 UART receiver with a 2-flop input synchronizer.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   i_rx           raw serial input (idle high)
//   o_byte         received byte, valid with o_byte_valid
//   o_byte_valid   one-cycle pulse when a byte with a good stop bit arrives
//   o_rx_err       one-cycle pulse when the stop bit is sampled low
//   o_start        one-cycle pulse when a start bit is confirmed at mid-bit
//   o_rx_sync      synchronized line level
module uart_rx_byte
  import uart_frame_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_rx_err,
  output logic       o_start,
  output logic       o_rx_sync
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_rx_d;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_err_wait;

  assign o_rx_sync = r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RX_IDLE;
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_rx_d       <= 1'b1;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_err_wait   <= 1'b0;
      o_byte       <= '0;
      o_byte_valid <= 1'b0;
      o_rx_err     <= 1'b0;
      o_start      <= 1'b0;
    end else begin
      r_sync1      <= i_rx;
      r_sync2      <= r_sync1;
      r_rx_d       <= r_sync2;
      o_byte_valid <= 1'b0;
      o_rx_err     <= 1'b0;
      o_start      <= 1'b0;
      unique case (r_state)
        RX_IDLE: begin
          r_cnt      <= '0;
          r_bit_idx  <= '0;
          r_err_wait <= 1'b0;
          if (r_rx_d && !r_sync2) r_state <= RX_START;
        end
        RX_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            if (!r_sync2) begin
              r_state <= RX_DATA;
              o_start <= 1'b1;
            end else begin
              r_state <= RX_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt     <= '0;
            r_shift   <= {r_sync2, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          // After a framing error, stay here until the line returns high so
          // the low stop bit is not mistaken for the next start edge.
          if (r_err_wait) begin
            if (r_sync2) r_state <= RX_IDLE;
          end else if (r_cnt == FULL_M1) begin
            r_cnt <= '0;
            if (r_sync2) begin
              o_byte       <= r_shift;
              o_byte_valid <= 1'b1;
              r_state      <= RX_IDLE;
            end else begin
              o_rx_err   <= 1'b1;
              r_err_wait <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_loader.sv
// uart_frame_loader: receives a 12-bit RGB image over UART, packs byte pairs
// into pixels and writes them to BRAM port B at {row, col}.
// Ports:
//   clk, rst     pixel clock, asynchronous active-high reset
//   rx           UART serial input (idle high)
//   wea          one-cycle write enable per pixel
//   addrb        write address {row[8:0], col[8:0]}
//   dinb         pixel {R, G, B}
//   frame_done   one-cycle pulse after the last pixel of a frame
//   rx_err       one-cycle pulse on framing error
//   busy         high from the first start bit of a frame until frame end or idle re-sync
module uart_frame_loader
  import uart_frame_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 25_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned IMG_W     = 320,
  parameter int unsigned IMG_H     = 240,
  parameter int unsigned IDLE_BITS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              wea,
  output logic [ADDR_W-1:0] addrb,
  output logic [PIX_W-1:0]  dinb,
  output logic              frame_done,
  output logic              rx_err,
  output logic              busy
);

  localparam int unsigned CPB       = clks_per_bit(CLK_HZ, BAUD);
  localparam logic [31:0] IDLE_M1   = 32'(IDLE_BITS * CPB - 1);
  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(IMG_H - 1);

  logic [7:0]         w_byte;
  logic               w_byte_valid;
  logic               w_rx_err;
  logic               w_start;
  logic               w_rx_sync;
  logic               w_idle_hit;

  logic               r_phase;
  logic [3:0]         r_red;
  logic [COORD_W-1:0] r_row;
  logic [COORD_W-1:0] r_col;
  logic               r_last;
  logic [31:0]        r_idle_cnt;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) u_rx (
    .clk          (clk),
    .rst          (rst),
    .i_rx         (rx),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_rx_err     (w_rx_err),
    .o_start      (w_start),
    .o_rx_sync    (w_rx_sync)
  );

  assign rx_err = w_rx_err;

  always_comb begin
    w_idle_hit = w_rx_sync && (busy || r_phase) && (r_idle_cnt == IDLE_M1)
                 && !w_byte_valid && !w_rx_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wea        <= 1'b0;
      addrb      <= '0;
      dinb       <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      r_phase    <= 1'b0;
      r_red      <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_last     <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      wea        <= 1'b0;
      r_last     <= 1'b0;
      frame_done <= r_last;

      // Timer only runs while something is pending; any low level restarts it.
      if (!w_rx_sync || !(busy || r_phase) || w_idle_hit) r_idle_cnt <= '0;
      else                                                r_idle_cnt <= r_idle_cnt + 1'b1;

      // A confirmed start bit wins over a frame end in the same cycle.
      if (w_start)                   busy <= 1'b1;
      else if (r_last || w_idle_hit) busy <= 1'b0;

      if (w_rx_err) begin
        r_phase <= 1'b0;
      end else if (w_byte_valid) begin
        if (!r_phase) begin
          r_red   <= w_byte[3:0];
          r_phase <= 1'b1;
        end else begin
          r_phase <= 1'b0;
          wea     <= 1'b1;
          addrb   <= {r_row, r_col};
          dinb    <= {r_red, w_byte};
          if (r_col == COL_LAST) begin
            r_col <= '0;
            if (r_row == ROW_LAST) begin
              r_row  <= '0;
              r_last <= 1'b1;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
      end else if (w_idle_hit) begin
        r_phase <= 1'b0;
        r_row   <= '0;
        r_col   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
module tb_uart_frame_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_s = 1'b1;
  logic        rx_d = 1'b1;

  logic        s_wea, s_fd, s_err, s_busy;
  logic [17:0] s_addr;
  logic [11:0] s_din;
  logic        d_wea, d_fd, d_err, d_busy;
  logic [17:0] d_addr;
  logic [11:0] d_din;

  int total = 0;
  int bad   = 0;

  logic [17:0] wa_q[$];
  logic [11:0] wd_q[$];
  time         wt_q[$];
  logic [17:0] dwa_q[$];
  logic [11:0] dwd_q[$];
  int          fd_n = 0;
  int          err_n = 0;
  time         fd_t = 0;
  time         t_stop = 0;

  // CLKS_PER_BIT = 921600 / 115200 = 8
  uart_frame_loader #(.CLK_HZ(921_600), .BAUD(115_200), .IMG_W(4), .IMG_H(2),
                      .IDLE_BITS(32)) dut_s (
    .clk(clk), .rst(rst), .rx(rx_s), .wea(s_wea), .addrb(s_addr), .dinb(s_din),
    .frame_done(s_fd), .rx_err(s_err), .busy(s_busy));

  // Default parameters: CLKS_PER_BIT = 217
  uart_frame_loader dut_d (
    .clk(clk), .rst(rst), .rx(rx_d), .wea(d_wea), .addrb(d_addr), .dinb(d_din),
    .frame_done(d_fd), .rx_err(d_err), .busy(d_busy));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (s_wea) begin
      wa_q.push_back(s_addr);
      wd_q.push_back(s_din);
      wt_q.push_back($time);
    end
    if (s_fd) begin
      fd_n++;
      fd_t = $time;
    end
    if (s_err) err_n++;
    if (d_wea) begin
      dwa_q.push_back(d_addr);
      dwd_q.push_back(d_din);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input bit dflt);
    if (dflt) rx_d = v;
    else      rx_s = v;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_bit, input bit dflt);
    int cpb;
    cpb = dflt ? 217 : 8;
    @(negedge clk);
    drive(1'b0, dflt);
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(b[i], dflt);
      repeat (cpb) @(negedge clk);
    end
    drive(stop_bit, dflt);
    if (!dflt) t_stop = $time;
    repeat (cpb) @(negedge clk);
    if (!stop_bit) begin
      drive(1'b1, dflt);
      repeat (2 * cpb) @(negedge clk);
    end
  endtask

  task automatic send_pix(input logic [7:0] b0, input logic [7:0] b1);
    send_byte(b0, 1'b1, 1'b0);
    send_byte(b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [17:0] exp_addr [8];
    logic [11:0] exp_din  [8];
    logic [7:0]  b0, b1;
    int          n;

    exp_addr = '{18'h00000, 18'h00001, 18'h00002, 18'h00003,
                 18'h00200, 18'h00201, 18'h00202, 18'h00203};

    repeat (3) @(negedge clk);
    chk("rst_wea", 32'(s_wea), 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_addrb", 32'(s_addr), 32'h0);
    chk("rst_dinb", 32'(s_din), 32'h0);
    chk("rst_frame_done", 32'(s_fd), 32'h0);
    chk("rst_rx_err", 32'(s_err), 32'h0);
    chk("rst_busy", 32'(s_busy), 32'h0);

    // Test 1: 0x0A, 0x5C -> A5C at address 0
    send_pix(8'h0A, 8'h5C);
    chk("t1_wea_count", 32'(wa_q.size()), 32'd1);
    chk("t1_addrb", 32'(wa_q[0]), 32'h0);
    chk("t1_dinb", 32'(wd_q[0]), 32'hA5C);
    // stop bit driven at negedge N; 2 sync flops + start detect + half bit
    // puts the stop sample 7 edges later and wea one edge after that.
    chk("t1_wea_latency", 32'(wt_q[0] - t_stop), 32'd80);
    chk("t1_busy", 32'(s_busy), 32'd1);

    // Test 2: complete the 4x2 frame; upper nibble of b0 is ignored
    exp_din[0] = 12'hA5C;
    for (int i = 1; i < 8; i++) begin
      b0 = 8'hF0 | 8'(i);
      b1 = 8'(i * 8'h13);
      exp_din[i] = {4'(i), b1};
      send_pix(b0, b1);
    end
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_addrb_%0d", i), 32'(wa_q[i]), 32'(exp_addr[i]));
      chk($sformatf("t2_dinb_%0d", i), 32'(wd_q[i]), 32'(exp_din[i]));
    end
    chk("t2_frame_done_count", 32'(fd_n), 32'd1);
    chk("t2_frame_done_timing", 32'(fd_t - wt_q[7]), 32'd10);
    chk("t2_busy_after", 32'(s_busy), 32'd0);
    send_pix(8'h01, 8'h23);
    chk("t2_wrap_addrb", 32'(wa_q[8]), 32'h0);
    chk("t2_wrap_dinb", 32'(wd_q[8]), 32'h123);

    // Test 3: one good byte, then a framing error resets the byte phase
    send_byte(8'h0F, 1'b1, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0);
    chk("t3_rx_err_count", 32'(err_n), 32'd1);
    chk("t3_no_wea", 32'(wa_q.size()), 32'd9);
    send_pix(8'h03, 8'h21);
    chk("t3_wea_count", 32'(wa_q.size()), 32'd10);
    chk("t3_addrb", 32'(wa_q[9]), 32'h1);
    chk("t3_dinb", 32'(wd_q[9]), 32'h321);

    // Test 4: 3 pixels + 1 byte, then idle re-sync
    send_pix(8'h04, 8'h44);
    send_pix(8'h05, 8'h55);
    send_pix(8'h06, 8'h66);
    send_byte(8'h07, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("t4_addrb_last", 32'(wa_q[12]), 32'h200);
    chk("t4_busy_before", 32'(s_busy), 32'd1);
    repeat (40 * 8) @(negedge clk);
    chk("t4_busy_after", 32'(s_busy), 32'd0);
    chk("t4_no_frame_done", 32'(fd_n), 32'd1);
    chk("t4_no_wea", 32'(wa_q.size()), 32'd13);
    send_pix(8'h08, 8'h88);
    chk("t4_resync_addrb", 32'(wa_q[13]), 32'h0);
    chk("t4_resync_dinb", 32'(wd_q[13]), 32'h888);

    // Test 5: half-bit glitch is rejected
    @(negedge clk);
    rx_s = 1'b0;
    repeat (4) @(negedge clk);
    rx_s = 1'b1;
    repeat (24) @(negedge clk);
    chk("t5_no_wea", 32'(wa_q.size()), 32'd14);
    chk("t5_no_rx_err", 32'(err_n), 32'd1);
    send_pix(8'h09, 8'hAB);
    chk("t5_addrb", 32'(wa_q[14]), 32'h1);
    chk("t5_dinb", 32'(wd_q[14]), 32'h9AB);

    // Test 6: reset during DATA of the second byte
    send_byte(8'h0B, 1'b1, 1'b0);
    @(negedge clk);
    rx_s = 1'b0;
    repeat (8) @(negedge clk);
    rx_s = 1'b1;
    repeat (16) @(negedge clk);
    rx_s = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_wea", 32'(s_wea), 32'h0);
    chk("t6_rst_addrb", 32'(s_addr), 32'h0);
    chk("t6_rst_dinb", 32'(s_din), 32'h0);
    chk("t6_rst_busy", 32'(s_busy), 32'h0);
    rx_s = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_no_partial_wea", 32'(wa_q.size()), 32'd15);
    send_pix(8'h07, 8'h89);
    n = wa_q.size();
    chk("t6_wea_count", 32'(n), 32'd16);
    chk("t6_addrb", 32'(wa_q[15]), 32'h0);
    chk("t6_dinb", 32'(wd_q[15]), 32'h789);

    // Default-parameter instance: one pixel
    send_byte(8'h0C, 1'b1, 1'b1);
    send_byte(8'hDE, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    chk("dflt_wea_count", 32'(dwa_q.size()), 32'd1);
    if (dwa_q.size() > 0) begin
      chk("dflt_addrb", 32'(dwa_q[0]), 32'h0);
      chk("dflt_dinb", 32'(dwd_q[0]), 32'hCDE);
    end
    chk("dflt_busy", 32'(d_busy), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
